mem_bus_responder: RTL and testbench

- Memory-side responder on the processor's 16-bit address bus.
- Accepts one request at a time: either an instruction fetch (PC-sourced) or a data load/store (address-bus-sourced).
- Inserts a configurable number of wait states, then returns a 32-bit response through a valid/ready handshake.
- Sits between the address-bus multiplexer and the word-addressed data/instruction RAM.

---
 rtl/mem_bus_responder.sv | 129 ++++++++++++
 tb/tb_mem_bus_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Single-outstanding memory responder: accepts a fetch or data access, waits
// WAIT_STATES cycles, commits to the internal RAM and holds the response until consumed.
module mem_bus_responder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_sel,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_sel
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic                    lat_sel_reg, lat_we_reg;
  logic [ADDR_WIDTH-1:0]   lat_addr_reg;
  logic [DATA_WIDTH-1:0]   lat_wdata_reg;
  logic                    rsp_err_reg, rsp_sel_reg, rsp_rd_reg;
  logic                    accept, commit;

  logic                    acc_sel, acc_we, acc_err;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic [IDX_W-1:0]        acc_idx;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   ram_q;

  // With zero wait states the commit edge is the accept edge, so the access
  // is taken straight from the request bus; otherwise from the latched copy.
  assign acc_sel   = (state_reg == IDLE) ? req_sel   : lat_sel_reg;
  assign acc_we    = (state_reg == IDLE) ? req_we    : lat_we_reg;
  assign acc_addr  = (state_reg == IDLE) ? req_addr  : lat_addr_reg;
  assign acc_wdata = (state_reg == IDLE) ? req_wdata : lat_wdata_reg;
  assign acc_idx   = acc_addr[IDX_W-1:0];
  assign acc_err   = ({1'b0, acc_addr} >= DEPTH_LIM) || (acc_sel && acc_we);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            commit     = 1'b1;
            state_next = RESP;
          end else begin
            cnt_next   = CNT_INIT;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          commit     = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      lat_sel_reg   <= 1'b0;
      lat_we_reg    <= 1'b0;
      lat_addr_reg  <= '0;
      lat_wdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_sel_reg   <= 1'b0;
      rsp_rd_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        lat_sel_reg   <= req_sel;
        lat_we_reg    <= req_we;
        lat_addr_reg  <= req_addr;
        lat_wdata_reg <= req_wdata;
      end
      if (commit) begin
        rsp_err_reg <= acc_err;
        rsp_sel_reg <= acc_sel;
        rsp_rd_reg  <= !acc_err && !acc_we;
      end
    end
  end

  // RAM is never reset; the registered read keeps tracking the in-flight
  // address, which cannot be written again until the response is consumed.
  always_ff @(posedge clk) begin
    if (commit && acc_we && !acc_err) mem[acc_idx] <= acc_wdata;
    ram_q <= mem[acc_idx];
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = (rsp_valid && rsp_rd_reg) ? ram_q : '0;
  assign rsp_err   = rsp_err_reg;
  assign rsp_sel   = rsp_sel_reg;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: one instance with two wait states, one with none,
// driven by a directed vector table, reset corner sequences and random traffic.
module tb_mem_bus_responder;

  logic        clk;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_sel   [2];
  logic [15:0] req_addr  [2];
  logic        req_we    [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        rsp_sel   [2];

  int          n_checks;
  int          n_fail;
  int          ws [2];
  logic [31:0] ref_mem [2][256];

  mem_bus_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_sel(req_sel[0]),
    .req_addr(req_addr[0]), .req_we(req_we[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .rsp_sel(rsp_sel[0])
  );

  mem_bus_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_sel(req_sel[1]),
    .req_addr(req_addr[1]), .req_we(req_we[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .rsp_sel(rsp_sel[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          sel;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
    int          hold;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Spec-level reference: out-of-range or fetch-with-write is an error; otherwise
  // a write updates the word and a read returns it.
  task automatic model(input int u, input bit sel, input bit we, input logic [15:0] addr,
                       input logic [31:0] wd, output bit e_err, output logic [31:0] e_rd);
    if (addr >= 16'd256 || (sel && we)) begin
      e_err = 1'b1;
      e_rd  = 32'h0;
    end else if (we) begin
      ref_mem[u][addr[7:0]] = wd;
      e_err = 1'b0;
      e_rd  = 32'h0;
    end else begin
      e_err = 1'b0;
      e_rd  = ref_mem[u][addr[7:0]];
    end
  endtask

  task automatic chk_reset(input int u, input string tag);
    chk({tag, " req_ready"}, 32'(req_ready[u]), 32'h1);
    chk({tag, " rsp_valid"}, 32'(rsp_valid[u]), 32'h0);
    chk({tag, " rsp_rdata"}, rsp_rdata[u], 32'h0);
    chk({tag, " rsp_err"},   32'(rsp_err[u]), 32'h0);
    chk({tag, " rsp_sel"},   32'(rsp_sel[u]), 32'h0);
  endtask

  task automatic scramble(input int u);
    req_sel[u]   = 1'($urandom);
    req_we[u]    = 1'($urandom);
    req_addr[u]  = 16'($urandom);
    req_wdata[u] = $urandom;
  endtask

  // Full handshake on instance u; called at a negedge, returns at a negedge.
  task automatic xact(input int u, input bit sel, input bit we, input logic [15:0] addr,
                      input logic [31:0] wd, input bit e_err, input logic [31:0] e_rd,
                      input int hold, input string tag);
    int k;
    k = 0;
    while (!req_ready[u] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " idle_ready"}, 32'(req_ready[u]), 32'h1);
    req_valid[u] = 1'b1;
    req_sel[u]   = sel;
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_wdata[u] = wd;
    rsp_ready[u] = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid[u] = 1'b0;
    scramble(u);
    k = 0;
    while (!rsp_valid[u] && k < 40) begin
      @(negedge clk);
      scramble(u);
      k++;
    end
    chk({tag, " latency"}, 32'(k), 32'(ws[u]));
    chk({tag, " rsp_err"}, 32'(rsp_err[u]), 32'(e_err));
    chk({tag, " rsp_rdata"}, rsp_rdata[u], e_rd);
    chk({tag, " rsp_sel"}, 32'(rsp_sel[u]), 32'(sel));
    chk({tag, " busy"}, 32'(req_ready[u]), 32'h0);
    for (int h = 0; h < hold; h++) begin
      req_valid[u] = 1'b1;
      scramble(u);
      @(negedge clk);
      chk({tag, " hold_valid"}, 32'(rsp_valid[u]), 32'h1);
      chk({tag, " hold_rdata"}, rsp_rdata[u], e_rd);
      chk({tag, " hold_err"}, 32'(rsp_err[u]), 32'(e_err));
      chk({tag, " hold_busy"}, 32'(req_ready[u]), 32'h0);
    end
    rsp_ready[u] = 1'b1;
    @(negedge clk);
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b0;
    chk({tag, " post_ready"}, 32'(req_ready[u]), 32'h1);
    chk({tag, " post_valid"}, 32'(rsp_valid[u]), 32'h0);
    $display("xact %-8s u=%0d sel=%0d we=%0d addr=%04h wdata=%08h -> err=%0d rdata=%08h lat=%0d hold=%0d",
             tag, u, sel, we, addr, wd, e_err, e_rd, k, hold);
  endtask

  initial begin
    bit          ee;
    logic [31:0] er;
    int          k;

    n_checks = 0;
    n_fail   = 0;
    ws[0] = 2;
    ws[1] = 0;
    for (int u = 0; u < 2; u++) begin
      for (int a = 0; a < 256; a++) ref_mem[u][a] = 32'h0;
      req_valid[u] = 1'b0; req_sel[u] = 1'b0; req_we[u] = 1'b0;
      req_addr[u] = 16'h0; req_wdata[u] = 32'h0; rsp_ready[u] = 1'b0;
    end

    vt[0]  = '{0, 1, 16'h0010, 32'h12345678, 0, 32'h0,        0};
    vt[1]  = '{1, 0, 16'h0010, 32'h0,        0, 32'h12345678, 0};
    vt[2]  = '{0, 0, 16'h0010, 32'h0,        0, 32'h12345678, 5};
    vt[3]  = '{0, 0, 16'h0100, 32'h0,        1, 32'h0,        0};
    vt[4]  = '{0, 1, 16'h0004, 32'h0BADF00D, 0, 32'h0,        0};
    vt[5]  = '{1, 1, 16'h0004, 32'hDEADBEEF, 1, 32'h0,        0};
    vt[6]  = '{0, 0, 16'h0004, 32'h0,        0, 32'h0BADF00D, 0};
    vt[7]  = '{0, 0, 16'hFFFF, 32'h0,        1, 32'h0,        0};
    vt[8]  = '{0, 1, 16'h00FF, 32'hCAFEF00D, 0, 32'h0,        0};
    vt[9]  = '{1, 0, 16'h00FF, 32'h0,        0, 32'hCAFEF00D, 2};
    vt[10] = '{1, 1, 16'h0011, 32'h55555555, 1, 32'h0,        0};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset(0, "in_reset");
    reset = 1'b0;
    @(negedge clk);
    chk_reset(0, "after_reset");
    chk_reset(1, "after_reset0");

    // Known RAM contents for every address the tests read.
    for (int u = 0; u < 2; u++) begin
      for (int a = 0; a < 65; a++) begin
        logic [15:0] pa;
        pa = (a == 64) ? 16'h00FF : 16'(a);
        model(u, 1'b0, 1'b1, pa, 32'h0, ee, er);
        xact(u, 1'b0, 1'b1, pa, 32'h0, ee, er, 0, "preload");
      end
    end

    for (int i = 0; i < 11; i++) begin
      model(0, vt[i].sel, vt[i].we, vt[i].addr, vt[i].wdata, ee, er);
      xact(0, vt[i].sel, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_err, vt[i].exp_rdata,
           vt[i].hold, "table");
    end

    // Reset during WAIT aborts the write to 0x0020.
    req_valid[0] = 1'b1; req_sel[0] = 1'b0; req_we[0] = 1'b1;
    req_addr[0] = 16'h0020; req_wdata[0] = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("wait_busy", 32'(req_ready[0]), 32'h0);
    reset = 1'b1;
    #1;
    chk_reset(0, "rst_in_wait");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    xact(0, 1'b0, 1'b0, 16'h0020, 32'h0, 1'b0, 32'h0, 0, "abort_rd");

    // Reset during RESP keeps the committed write but drops the response.
    req_valid[0] = 1'b1; req_sel[0] = 1'b0; req_we[0] = 1'b1;
    req_addr[0] = 16'h0030; req_wdata[0] = 32'h11112222;
    rsp_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    k = 0;
    while (!rsp_valid[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("resp_reached", 32'(rsp_valid[0]), 32'h1);
    reset = 1'b1;
    #1;
    chk_reset(0, "rst_in_resp");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model(0, 1'b0, 1'b1, 16'h0030, 32'h11112222, ee, er);
    xact(0, 1'b0, 1'b0, 16'h0030, 32'h0, 1'b0, 32'h11112222, 0, "resp_rd");

    // Zero-wait-state back-to-back write/read pairs.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      d = $urandom;
      model(1, 1'b0, 1'b1, 16'(i), d, ee, er);
      xact(1, 1'b0, 1'b1, 16'(i), d, 1'b0, 32'h0, 0, "b2b_wr");
      xact(1, 1'b0, 1'b0, 16'(i), 32'h0, 1'b0, d, 0, "b2b_rd");
    end

    // Random traffic against the reference model on both instances.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 60; i++) begin
        bit          s, w;
        logic [15:0] a;
        logic [31:0] d;
        int          r;
        s = ($urandom_range(0, 3) == 0);
        w = ($urandom_range(0, 1) == 1);
        if (s && $urandom_range(0, 3) != 0) w = 1'b0;
        r = $urandom_range(0, 9);
        a = (r == 0) ? 16'($urandom_range(256, 65535)) : 16'($urandom_range(0, 31));
        if (r == 1) a = 16'hFFFF;
        d = $urandom;
        model(u, s, w, a, d, ee, er);
        xact(u, s, w, a, d, ee, er, $urandom_range(0, 2), "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
